// File: rtl/pid_cfg_spi_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : pid_cfg_spi_if
// Brief    : SPI pins plus PID register-write bus for the gain config port.
//            master = host/consumer side, slave = pid_cfg_spi.
// Revision : 1.0 - initial release
// ============================================================================
interface pid_cfg_spi_if #(
   parameter int D_WIDTH = 18
);
   logic               sclk;
   logic               cs_n;
   logic               mosi;
   logic               miso;
   logic               write_enable;
   logic [D_WIDTH-1:0] reg_addr;
   logic [D_WIDTH-1:0] reg_data;
   logic               busy;
   logic [7:0]         err_count;

   modport master (
      output sclk, cs_n, mosi,
      input  miso, write_enable, reg_addr, reg_data, busy, err_count
   );

   modport slave (
      input  sclk, cs_n, mosi,
      output miso, write_enable, reg_addr, reg_data, busy, err_count
   );
endinterface
`default_nettype wire

// File: rtl/pid_cfg_spi.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : pid_cfg_spi
// Brief    : Oversampled SPI-slave (mode 0) that writes the PID gain registers
//            with a single-cycle active-low strobe and keeps shadow copies
//            of the gains for read-back over MISO.
// Revision : 1.0 - initial release
// ============================================================================
module pid_cfg_spi #(
   parameter int D_WIDTH     = 18,
   parameter int ADDR_BITS   = 7,
   parameter int NUM_REGS    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic    clock,
   input  wire logic    reset,
   pid_cfg_spi_if.slave bus
);

   localparam int c_FRAME_BITS = 1 + ADDR_BITS + D_WIDTH;
   localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 2);
   localparam int c_IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int c_FL_W       = $clog2(SYNC_STAGES + 2);

   localparam logic [c_CNT_W-1:0]   c_CNT_FRAME  = c_CNT_W'(c_FRAME_BITS);
   localparam logic [c_CNT_W-1:0]   c_CNT_MAX    = c_CNT_W'(c_FRAME_BITS + 1);
   localparam logic [c_CNT_W-1:0]   c_CNT_HDR    = c_CNT_W'(1 + ADDR_BITS);
   localparam logic [c_CNT_W-1:0]   c_CNT_HDR_M1 = c_CNT_W'(ADDR_BITS);
   localparam logic [c_FL_W-1:0]    c_FLUSH      = c_FL_W'(SYNC_STAGES + 1);
   localparam logic [ADDR_BITS:0]   c_NUM_REGS   = (ADDR_BITS + 1)'(NUM_REGS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RECV   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]               r_state;
   logic [1:0]               w_next_state;

   logic [SYNC_STAGES-1:0]   r_sclk_sync;
   logic [SYNC_STAGES-1:0]   r_cs_sync;
   logic [SYNC_STAGES-1:0]   r_mosi_sync;
   logic                     r_sclk_d;
   logic                     r_cs_d;
   logic                     w_sclk_s;
   logic                     w_cs_s;
   logic                     w_mosi_s;
   logic                     w_sclk_rise;
   logic                     w_sclk_fall;
   logic                     w_cs_rise;
   logic                     w_cs_fall;

   logic [c_FL_W-1:0]        r_flush_cnt;
   logic                     r_armed;
   logic                     r_pend;

   logic [c_CNT_W-1:0]       r_bit_cnt;
   logic [c_FRAME_BITS-1:0]  r_rx;
   logic [c_FRAME_BITS-1:0]  w_rx_next;
   logic [D_WIDTH-1:0]       r_tx;
   logic [D_WIDTH-1:0]       r_shadow [NUM_REGS];

   logic [ADDR_BITS:0]       w_hdr;
   logic                     w_hdr_ok;
   logic                     w_rw;
   logic [ADDR_BITS-1:0]     w_addr;
   logic [D_WIDTH-1:0]       w_data;
   logic                     w_addr_ok;

   logic                     w_start;
   logic                     w_commit_wr;
   logic                     w_commit_err;
   logic                     w_busy;
   logic                     w_miso;

   logic                     r_we_n;
   logic [D_WIDTH-1:0]       r_reg_addr;
   logic [D_WIDTH-1:0]       r_reg_data;
   logic [7:0]               r_err_count;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_cs_rise   = w_cs_s & ~r_cs_d;
   assign w_cs_fall   = ~w_cs_s & r_cs_d;

   // Header as it will stand once the current sclk rise is shifted in.
   assign w_rx_next = {r_rx[c_FRAME_BITS-2:0], w_mosi_s};
   assign w_hdr     = {r_rx[ADDR_BITS-1:0], w_mosi_s};
   assign w_hdr_ok  = ({1'b0, w_hdr[ADDR_BITS-1:0]} < c_NUM_REGS);

   assign w_rw      = r_rx[c_FRAME_BITS-1];
   assign w_addr    = r_rx[c_FRAME_BITS-2 -: ADDR_BITS];
   assign w_data    = r_rx[D_WIDTH-1:0];
   assign w_addr_ok = ({1'b0, w_addr} < c_NUM_REGS);

   assign w_start = (r_state == S_IDLE) && (w_next_state == S_RECV);

   // Oversample the SPI pins and keep one delayed copy for edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         r_sclk_d    <= w_sclk_s;
         r_cs_d      <= w_cs_s;
      end
   end

   // Arm frame start only after the synchronizer has flushed its reset value
   // and cs_n has been seen high, so a frame already running at reset
   // release is ignored; also remember a cs_n fall that lands in COMMIT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_flush_cnt <= '0;
         r_armed     <= 1'b0;
         r_pend      <= 1'b0;
      end else begin
         if (r_flush_cnt != c_FLUSH) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end else if (w_cs_s) begin
            r_armed <= 1'b1;
         end
         if (r_state == S_COMMIT && w_cs_fall) begin
            r_pend <= 1'b1;
         end else if (r_state == S_IDLE) begin
            r_pend <= 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if ((w_cs_fall && r_armed) || r_pend) w_next_state = S_RECV;
         S_RECV:   if (w_cs_rise) w_next_state = S_COMMIT;
         S_COMMIT: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs: frame verdict in COMMIT, busy flag and MISO gating.
   always_comb begin
      w_commit_wr  = 1'b0;
      w_commit_err = 1'b0;
      w_busy       = 1'b0;
      w_miso       = 1'b0;
      case (r_state)
         S_RECV: begin
            w_busy = 1'b1;
            if (r_bit_cnt >= c_CNT_HDR) w_miso = r_tx[D_WIDTH-1];
         end
         S_COMMIT: begin
            w_busy = 1'b1;
            if (r_bit_cnt == c_CNT_FRAME && w_addr_ok) begin
               w_commit_wr = ~w_rw;
            end else begin
               w_commit_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Receive shifter, bit counter and read-back transmit shifter.
   // The first data-phase sclk fall only exposes the freshly loaded MSB;
   // later falls advance to the next bit so the host samples all D_WIDTH.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_bit_cnt <= '0;
         r_rx      <= '0;
         r_tx      <= '0;
      end else if (w_start) begin
         r_bit_cnt <= '0;
         r_rx      <= '0;
         r_tx      <= '0;
      end else if (r_state == S_RECV) begin
         if (w_sclk_rise) begin
            r_rx <= w_rx_next;
            if (r_bit_cnt != c_CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_CNT_HDR_M1 && w_hdr[ADDR_BITS]) begin
               r_tx <= w_hdr_ok ? r_shadow[w_hdr[c_IDX_W-1:0]] : '0;
            end
         end else if (w_sclk_fall && r_bit_cnt > c_CNT_HDR) begin
            r_tx <= {r_tx[D_WIDTH-2:0], 1'b0};
         end
      end
   end

   // Register-write strobe, held address/data, shadows and error counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_we_n      <= 1'b1;
         r_reg_addr  <= '0;
         r_reg_data  <= '0;
         r_err_count <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      end else begin
         r_we_n <= ~w_commit_wr;
         if (w_commit_wr) begin
            r_reg_addr                 <= {{(D_WIDTH-ADDR_BITS){1'b0}}, w_addr};
            r_reg_data                 <= w_data;
            r_shadow[w_addr[c_IDX_W-1:0]] <= w_data;
         end
         if (w_commit_err && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   assign bus.miso         = w_miso;
   assign bus.write_enable = r_we_n;
   assign bus.reg_addr     = r_reg_addr;
   assign bus.reg_data     = r_reg_data;
   assign bus.busy         = w_busy;
   assign bus.err_count    = r_err_count;

endmodule
`default_nettype wire
